// File: rtl/mapper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mapper_pkg
// Description : Shared definitions for the ASCII mapper: CPU window limits,
//               bank-size mode enum, SRAM flag bit positions and small
//               address-decode helpers used by the top and the register file.
// Options     : MAPPER_SRAM_EN (consumers only; nothing here depends on it)
// Revision    : 1.0 - initial release
// ============================================================================
package mapper_pkg;

    typedef enum logic {
        MODE_8K  = 1'b0,
        MODE_16K = 1'b1
    } mode_e;

    // CPU address windows
    localparam logic [15:0] c_win_rom_lo  = 16'h4000;
    localparam logic [15:0] c_win_rom_hi  = 16'hBFFF;
    localparam logic [15:0] c_win_wr_lo   = 16'h6000;
    localparam logic [15:0] c_win_wr_hi   = 16'h7FFF;
    localparam logic [15:0] c_win_sram_lo = 16'h8000;

    // din bit that carries the SRAM flag in each mode
    localparam int c_sram_bit_8k  = 5;
    localparam int c_sram_bit_16k = 4;

    // True when a write at address a targets a bank register in mode m.
    // In 16 KB mode only the lower half of each 4 KB write slot is decoded.
    function automatic logic wr_hit(input mode_e m, input logic [15:0] a);
        logic in_win;
        in_win = (a >= c_win_wr_lo) && (a <= c_win_wr_hi);
        return (m == MODE_8K) ? in_win : (in_win && !a[11]);
    endfunction

    // Bank register index addressed by a write (valid only when wr_hit).
    function automatic logic [1:0] wr_idx(input mode_e m, input logic [15:0] a);
        return (m == MODE_8K) ? a[12:11] : {1'b0, a[12]};
    endfunction

    // Bank register index that maps a read at address a.
    // 8 KB mode: 4000/6000/8000/A000 -> 0/1/2/3, i.e. a[14:13] offset by two.
    function automatic logic [1:0] rd_idx(input mode_e m, input logic [15:0] a);
        return (m == MODE_8K) ? 2'(a[14:13] + 2'd2) : {1'b0, a[15]};
    endfunction

    function automatic logic sram_flag_bit(input mode_e m, input logic [7:0] d);
        return (m == MODE_8K) ? d[c_sram_bit_8k] : d[c_sram_bit_16k];
    endfunction

    function automatic logic in_sram_win(input logic [15:0] a);
        return (a >= c_win_sram_lo) && (a <= c_win_rom_hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mapper_bank_regs.sv
`default_nettype none
// ============================================================================
// Module      : mapper_bank_regs
// Description : Per-context bank register file and write-commit logic.
//               A commit happens on the first cycle of cs & mreq & wr; a held
//               strobe commits once. After reset the strobe must be seen low
//               before another commit is accepted, so a write that straddles
//               reset is dropped.
// Options     : MAPPER_SRAM_EN - adds per-bank SRAM flags and the
//               first-write-cycle output used for the SRAM write strobe.
// Ports       : clk, reset_n       - clock, async active-low reset
//               i_cs/i_cpu_mreq/i_cpu_wr/i_cpu_addr/i_din - CPU bus
//               i_cart_num, i_mode - active context and per-context mode
//               o_mode             - mode bit of the active context
//               o_wr_first         - first cycle of a CPU write (SRAM build)
//               o_sram_flags       - SRAM flags of active context (SRAM build)
//               o_banks            - b3..b0 of active context, packed
// Revision    : 1.0 - initial release
// ============================================================================
module mapper_bank_regs #(
    parameter int CART_CNT   = 2,
    parameter int BANK_W     = 8,
    parameter int CART_SEL_W = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_cs,
    input  logic                  i_cpu_mreq,
    input  logic                  i_cpu_wr,
    input  logic [15:0]           i_cpu_addr,
    input  logic [7:0]            i_din,
    input  logic [CART_SEL_W-1:0] i_cart_num,
    input  logic [CART_CNT-1:0]   i_mode,
    output logic                  o_mode,
`ifdef MAPPER_SRAM_EN
    output logic                  o_wr_first,
    output logic [3:0]            o_sram_flags,
`endif
    output logic [4*BANK_W-1:0]   o_banks
);
    import mapper_pkg::*;

    logic              w_wr_term;
    logic              r_wr_prev;
    logic              r_armed;
    logic              w_wr_first;
    logic              w_cart_ok;
    logic              w_mode_bit;
    mode_e             w_mode;
    logic              w_hit;
    logic [1:0]        w_idx;
    logic              w_commit;
    logic [BANK_W-1:0] w_din_bank;

    logic [4*BANK_W-1:0] w_ctx_banks [CART_CNT];

    assign w_wr_term = i_cs & i_cpu_mreq & i_cpu_wr;

    // r_armed stays low from reset until the strobe has been seen low once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_prev <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_wr_prev <= w_wr_term;
            if (!w_wr_term) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_wr_first = w_wr_term & ~r_wr_prev & r_armed;

    // cart_num codes beyond CART_CNT select nothing
    assign w_cart_ok  = (32'(i_cart_num) < CART_CNT);
    assign w_mode_bit = w_cart_ok ? i_mode[i_cart_num] : 1'b0;
    assign w_mode     = mode_e'(w_mode_bit);
    assign w_hit      = wr_hit(w_mode, i_cpu_addr);
    assign w_idx      = wr_idx(w_mode, i_cpu_addr);
    assign w_commit   = w_wr_first & w_hit & w_cart_ok;
    // Narrower banks drop high din bits, wider banks zero-fill
    assign w_din_bank = BANK_W'(i_din);

`ifdef MAPPER_SRAM_EN
    logic       w_flag_bit;
    logic [3:0] w_ctx_flags [CART_CNT];
    assign w_flag_bit = sram_flag_bit(w_mode, i_din);
`endif

    for (genvar c = 0; c < CART_CNT; c++) begin : g_ctx
        logic                w_sel;
        logic [4*BANK_W-1:0] r_banks;

        assign w_sel = w_commit && (i_cart_num == CART_SEL_W'(c));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_banks <= '0;
            end else if (w_sel) begin
                r_banks[w_idx*BANK_W +: BANK_W] <= w_din_bank;
            end
        end

        assign w_ctx_banks[c] = r_banks;

`ifdef MAPPER_SRAM_EN
        logic [3:0] r_flags;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_flags <= 4'b0;
            end else if (w_sel) begin
                r_flags[w_idx] <= w_flag_bit;
            end
        end

        assign w_ctx_flags[c] = r_flags;
`endif
    end

    assign o_mode  = w_mode_bit;
    assign o_banks = w_cart_ok ? w_ctx_banks[i_cart_num] : '0;

`ifdef MAPPER_SRAM_EN
    assign o_wr_first   = w_wr_first;
    assign o_sram_flags = w_cart_ok ? w_ctx_flags[i_cart_num] : 4'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/mapper_ascii_gen.sv
`default_nettype none
// ============================================================================
// Module      : mapper_ascii_gen
// Description : Generic ASCII 8 KB / 16 KB cartridge mapper with CART_CNT
//               independent contexts. Translates the CPU address in
//               4000-BFFF into a ROM address from the bank registers and
//               flags accesses beyond the ROM image.
// Options     : MAPPER_SRAM_EN - per-bank SRAM flag; a flagged bank in
//               8000-BFFF routes the access to a 8 KB SRAM window.
// Ports       : clk, reset_n          - clock, async active-low reset
//               cpu_addr, din          - CPU address / write data
//               cpu_mreq, cpu_wr, cs   - strobes and slot select
//               cart_num, mode         - active context, per-context mode
//               rom_size               - ROM image size in bytes
//               mem_addr, mem_unmaped  - translated address, out-of-image
//               sram_sel/we/addr       - SRAM window controls
// Revision    : 1.0 - initial release
// ============================================================================
module mapper_ascii_gen #(
    parameter  int CART_CNT   = 2,
    parameter  int BANK_W     = 8,
    parameter  int ADDR_W     = 25,
    localparam int CART_SEL_W = (CART_CNT > 1) ? $clog2(CART_CNT) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [15:0]           cpu_addr,
    input  logic [7:0]            din,
    input  logic                  cpu_mreq,
    input  logic                  cpu_wr,
    input  logic                  cs,
    input  logic [CART_SEL_W-1:0] cart_num,
    input  logic [CART_CNT-1:0]   mode,
    input  logic [ADDR_W-1:0]     rom_size,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_unmaped,
    output logic                  sram_sel,
    output logic                  sram_we,
    output logic [12:0]           sram_addr
);
    import mapper_pkg::*;

    logic                w_mode_bit;
    mode_e               w_mode;
    logic [4*BANK_W-1:0] w_banks;
    logic [1:0]          w_rd_idx;
    logic [BANK_W-1:0]   w_bank;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic                w_beyond;

`ifdef MAPPER_SRAM_EN
    logic                w_wr_first;
    logic [3:0]          w_sram_flags;
    logic                w_sram_sel;
`endif

    mapper_bank_regs #(
        .CART_CNT   (CART_CNT),
        .BANK_W     (BANK_W),
        .CART_SEL_W (CART_SEL_W)
    ) u_bank_regs (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_cs         (cs),
        .i_cpu_mreq   (cpu_mreq),
        .i_cpu_wr     (cpu_wr),
        .i_cpu_addr   (cpu_addr),
        .i_din        (din),
        .i_cart_num   (cart_num),
        .i_mode       (mode),
        .o_mode       (w_mode_bit),
`ifdef MAPPER_SRAM_EN
        .o_wr_first   (w_wr_first),
        .o_sram_flags (w_sram_flags),
`endif
        .o_banks      (w_banks)
    );

    assign w_mode   = mode_e'(w_mode_bit);
    assign w_rd_idx = rd_idx(w_mode, cpu_addr);
    assign w_bank   = w_banks[w_rd_idx*BANK_W +: BANK_W];

    always_comb begin
        w_mem_addr = '0;
        if (w_mode == MODE_8K) begin
            w_mem_addr = ADDR_W'({w_bank, cpu_addr[12:0]});
        end else begin
            w_mem_addr = ADDR_W'({w_bank, cpu_addr[13:0]});
        end
    end

    assign mem_addr = w_mem_addr;
    // rom_size = 0 makes every access "beyond" the image
    assign w_beyond = (w_mem_addr >= rom_size);

`ifdef MAPPER_SRAM_EN
    // A flagged bank only turns into SRAM in the upper window; below 8000
    // it keeps behaving as ROM.
    assign w_sram_sel  = cs & in_sram_win(cpu_addr) & w_sram_flags[w_rd_idx];
    assign sram_sel    = w_sram_sel;
    assign sram_we     = w_sram_sel & w_wr_first;
    assign sram_addr   = w_sram_sel ? cpu_addr[12:0] : 13'd0;
    assign mem_unmaped = cs & w_beyond & ~w_sram_sel;
`else
    assign sram_sel    = 1'b0;
    assign sram_we     = 1'b0;
    assign sram_addr   = 13'd0;
    assign mem_unmaped = cs & w_beyond;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mapper_ascii_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_mapper_ascii_gen
// Description : Directed self-checking bench for mapper_ascii_gen (default
//               parameters). SRAM expectations follow MAPPER_SRAM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mapper_ascii_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  din;
    logic        cpu_mreq;
    logic        cpu_wr;
    logic        cs;
    logic [0:0]  cart_num;
    logic [1:0]  mode;
    logic [24:0] rom_size;
    logic [24:0] mem_addr;
    logic        mem_unmaped;
    logic        sram_sel;
    logic        sram_we;
    logic [12:0] sram_addr;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mapper_ascii_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_addr    (cpu_addr),
        .din         (din),
        .cpu_mreq    (cpu_mreq),
        .cpu_wr      (cpu_wr),
        .cs          (cs),
        .cart_num    (cart_num),
        .mode        (mode),
        .rom_size    (rom_size),
        .mem_addr    (mem_addr),
        .mem_unmaped (mem_unmaped),
        .sram_sel    (sram_sel),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr)
    );

    task automatic bus_idle();
        cs       = 1'b0;
        cpu_mreq = 1'b0;
        cpu_wr   = 1'b0;
    endtask

    // One-cycle write: strobe is low at the preceding edge, high at the commit edge
    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_addr = a; din = d; cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1;
        @(posedge clk); #1;
        bus_idle();
    endtask

    // Read access set up mid-cycle; outputs are combinational
    task automatic rd(input logic [15:0] a);
        @(negedge clk);
        cpu_addr = a; cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cart_num = 1'b0; mode = 2'b00; rom_size = 25'h100_0000;
        din = 8'h00; cpu_addr = 16'h8123; cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1;
        #12;
        n_total++; if (mem_addr !== 25'h0123) $display("FAIL reset_mem_addr: got %h want %h", mem_addr, 25'h0123); else n_pass++;
        n_total++; if (mem_unmaped !== 1'b0) $display("FAIL reset_unmaped: got %b want 0", mem_unmaped); else n_pass++;
        n_total++; if (sram_sel !== 1'b0 || sram_we !== 1'b0) $display("FAIL reset_sram: got sel=%b we=%b want 0/0", sram_sel, sram_we); else n_pass++;
        rom_size = 25'h0; #1;
        n_total++; if (mem_unmaped !== 1'b1) $display("FAIL reset_unmaped_size0: got %b want 1", mem_unmaped); else n_pass++;
        rom_size = 25'h100_0000;
        bus_idle();
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_cart_ctx();
        mode = 2'b00;
        cart_num = 1'b1; do_write(16'h6000, 8'h02);
        rd(16'h4010);
        n_total++; if (mem_addr !== 25'h4010) $display("FAIL ctx1_b0: got %h want %h", mem_addr, 25'h4010); else n_pass++;
        cart_num = 1'b0; rd(16'h4010);
        n_total++; if (mem_addr !== 25'h0010) $display("FAIL ctx0_b0: got %h want %h", mem_addr, 25'h0010); else n_pass++;
        // cart_num flips after the commit edge while the strobe is still held
        @(posedge clk); #1;
        cart_num = 1'b1; cpu_addr = 16'h6800; din = 8'h09; cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1;
        @(posedge clk); #1;
        cart_num = 1'b0; din = 8'h0F;
        @(posedge clk); #1;
        bus_idle();
        rd(16'h6800);
        n_total++; if (mem_addr !== 25'h0800) $display("FAIL ctx_switch_ctx0: got %h want %h", mem_addr, 25'h0800); else n_pass++;
        cart_num = 1'b1; rd(16'h6800);
        n_total++; if (mem_addr !== 25'h12800) $display("FAIL ctx_switch_ctx1: got %h want %h", mem_addr, 25'h12800); else n_pass++;
        cart_num = 1'b0;
    endtask

    task automatic test_mode0();
        mode = 2'b00;
        do_write(16'h7000, 8'h05);
        rd(16'h8123);
        n_total++; if (mem_addr !== 25'hA123) $display("FAIL m0_b2: got %h want %h", mem_addr, 25'hA123); else n_pass++;
        n_total++; if (mem_unmaped !== 1'b0) $display("FAIL m0_mapped: got %b want 0", mem_unmaped); else n_pass++;
        do_write(16'h6000, 8'h11);
        do_write(16'h6FFF, 8'h22);
        do_write(16'h7800, 8'h33);
        rd(16'h4000);
        n_total++; if (mem_addr !== 25'h22000) $display("FAIL m0_b0: got %h want %h", mem_addr, 25'h22000); else n_pass++;
        rd(16'h6001);
        n_total++; if (mem_addr !== 25'h44001) $display("FAIL m0_b1: got %h want %h", mem_addr, 25'h44001); else n_pass++;
        rd(16'hA005);
        n_total++; if (mem_addr !== 25'h66005) $display("FAIL m0_b3: got %h want %h", mem_addr, 25'h66005); else n_pass++;
        rd(16'h8123);
        n_total++; if (mem_addr !== 25'hA123) $display("FAIL m0_b2_kept: got %h want %h", mem_addr, 25'hA123); else n_pass++;
    endtask

    task automatic test_mode1();
        mode = 2'b01;
        do_write(16'h6000, 8'h03);
        rd(16'h4010);
        n_total++; if (mem_addr !== 25'hC010) $display("FAIL m1_b0: got %h want %h", mem_addr, 25'hC010); else n_pass++;
        do_write(16'h6800, 8'h7F);
        do_write(16'h7800, 8'h7E);
        rd(16'h4010);
        n_total++; if (mem_addr !== 25'hC010) $display("FAIL m1_ignored_b0: got %h want %h", mem_addr, 25'hC010); else n_pass++;
        rd(16'h8000);
        n_total++; if (mem_addr !== 25'h88000) $display("FAIL m1_ignored_b1: got %h want %h", mem_addr, 25'h88000); else n_pass++;
        do_write(16'h7000, 8'h01);
        rd(16'h8004);
        n_total++; if (mem_addr !== 25'h4004) $display("FAIL m1_b1: got %h want %h", mem_addr, 25'h4004); else n_pass++;
        rd(16'h7FFF);
        n_total++; if (mem_addr !== 25'hFFFF) $display("FAIL m1_top_of_b0: got %h want %h", mem_addr, 25'hFFFF); else n_pass++;
        mode = 2'b00;
        rd(16'hA005);
        n_total++; if (mem_addr !== 25'h66005) $display("FAIL m1_b3_untouched: got %h want %h", mem_addr, 25'h66005); else n_pass++;
        rd(16'h6001);
        n_total++; if (mem_addr !== 25'h2001) $display("FAIL m1_b1_in_m0: got %h want %h", mem_addr, 25'h2001); else n_pass++;
    endtask

    task automatic test_held_strobe();
        mode = 2'b00;
        @(posedge clk); #1;
        cpu_addr = 16'h6800; din = 8'h40; cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(posedge clk); #1;
            din = 8'h40 + 8'(i);
        end
        @(posedge clk); #1;
        bus_idle();
        rd(16'h6800);
        n_total++; if (mem_addr !== 25'h80800) $display("FAIL held_strobe: got %h want %h", mem_addr, 25'h80800); else n_pass++;
    endtask

    task automatic test_unmapped();
        mode = 2'b00; rom_size = 25'h8000;
        do_write(16'h7000, 8'h04);
        rd(16'h8000);
        n_total++; if (mem_addr !== 25'h8000) $display("FAIL unm_addr: got %h want %h", mem_addr, 25'h8000); else n_pass++;
        n_total++; if (mem_unmaped !== 1'b1) $display("FAIL unm_at_size: got %b want 1", mem_unmaped); else n_pass++;
        rd(16'h4000);
        n_total++; if (mem_unmaped !== 1'b0) $display("FAIL unm_below: got %b want 0 (addr %h)", mem_unmaped, mem_addr); else n_pass++;
        do_write(16'h7000, 8'h03);
        rd(16'h9FFF);
        n_total++; if (mem_addr !== 25'h7FFF || mem_unmaped !== 1'b0) $display("FAIL unm_last_byte: got %h/%b want %h/0", mem_addr, mem_unmaped, 25'h7FFF); else n_pass++;
        rom_size = 25'h0;
        rd(16'h4000);
        n_total++; if (mem_unmaped !== 1'b1) $display("FAIL unm_size0: got %b want 1", mem_unmaped); else n_pass++;
        cs = 1'b0; #1;
        n_total++; if (mem_unmaped !== 1'b0) $display("FAIL unm_no_cs: got %b want 0", mem_unmaped); else n_pass++;
        rom_size = 25'h100_0000;
    endtask

    task automatic test_sram();
        int we_cnt;
        we_cnt = 0;
        mode = 2'b00; rom_size = 25'h0;
        do_write(16'h7000, 8'h20);
        @(posedge clk); #1;
        cpu_addr = 16'h8010; din = 8'hAA; cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sram_we === 1'b1) we_cnt++;
            if (i == 0) begin
                n_total++; if (mem_addr !== 25'h40010) $display("FAIL sram_bank_bits: got %h want %h", mem_addr, 25'h40010); else n_pass++;
`ifdef MAPPER_SRAM_EN
                n_total++; if (sram_sel !== 1'b1) $display("FAIL sram_sel: got %b want 1", sram_sel); else n_pass++;
                n_total++; if (sram_addr !== 13'h0010) $display("FAIL sram_addr: got %h want %h", sram_addr, 13'h0010); else n_pass++;
                n_total++; if (mem_unmaped !== 1'b0) $display("FAIL sram_unmaped: got %b want 0", mem_unmaped); else n_pass++;
`else
                n_total++; if (sram_sel !== 1'b0) $display("FAIL sram_sel_tied: got %b want 0", sram_sel); else n_pass++;
                n_total++; if (sram_addr !== 13'h0000) $display("FAIL sram_addr_tied: got %h want 0", sram_addr); else n_pass++;
                n_total++; if (mem_unmaped !== 1'b1) $display("FAIL sram_off_unmaped: got %b want 1", mem_unmaped); else n_pass++;
`endif
            end
        end
        @(posedge clk); #1;
        bus_idle();
`ifdef MAPPER_SRAM_EN
        n_total++; if (we_cnt != 1) $display("FAIL sram_we_pulses: got %0d want 1", we_cnt); else n_pass++;
        // flagged bank below 8000 stays ROM
        do_write(16'h6000, 8'h20);
        rd(16'h4000);
        n_total++; if (sram_sel !== 1'b0 || mem_addr !== 25'h40000) $display("FAIL sram_low_rom: got sel=%b addr=%h want 0/%h", sram_sel, mem_addr, 25'h40000); else n_pass++;
`else
        n_total++; if (we_cnt != 0) $display("FAIL sram_we_tied: got %0d pulses want 0", we_cnt); else n_pass++;
`endif
        rom_size = 25'h100_0000;
    endtask

    task automatic test_reset_mid_write();
        mode = 2'b00;
        do_write(16'h6800, 8'h15);
        rd(16'h6800);
        n_total++; if (mem_addr !== 25'h2A800) $display("FAIL rmw_before: got %h want %h", mem_addr, 25'h2A800); else n_pass++;
        @(posedge clk); #1;
        cpu_addr = 16'h6800; din = 8'h2A; cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1;
        #2; reset_n = 1'b0; #1;
        n_total++; if (mem_addr !== 25'h0800) $display("FAIL rmw_async_clear: got %h want %h", mem_addr, 25'h0800); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1; din = 8'h2B;
        @(negedge clk);
        n_total++; if (mem_addr !== 25'h0800) $display("FAIL rmw_held_no_commit: got %h want %h", mem_addr, 25'h0800); else n_pass++;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        @(posedge clk); #1;
        cpu_wr = 1'b1; din = 8'h2C;
        @(posedge clk); #1;
        bus_idle();
        rd(16'h6800);
        n_total++; if (mem_addr !== 25'h58800) $display("FAIL rmw_rearm_commit: got %h want %h", mem_addr, 25'h58800); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cart_ctx();
        test_mode0();
        test_mode1();
        test_held_strobe();
        test_unmapped();
        test_sram();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mapper_ascii_gen.md
MAPPER_ASCII_GEN -- requirements
Module: mapper_ascii_gen

Interface
REQ-001 The block SHALL have parameter CART_CNT, default 2, meaning number of independent cartridge contexts.
REQ-002 The block SHALL have parameter BANK_W, default 8, meaning bank register width in bits.
REQ-003 The block SHALL have parameter ADDR_W, default 25, meaning width of mem_addr and rom_size.
REQ-004 The block SHALL have port clk, input, 1, the single clock.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port cpu_addr, input, 16, the CPU address.
REQ-007 The block SHALL have port din, input, 8, CPU write data.
REQ-008 The block SHALL have ports cpu_mreq and cpu_wr, input, 1 each, CPU memory request and write strobes.
REQ-009 The block SHALL have port cs, input, 1, slot select.
REQ-010 The block SHALL have port cart_num, input, $clog2(CART_CNT) (minimum 1), active context.
REQ-011 The block SHALL have port mode, input, CART_CNT, per-context mode where 0 = 8 KB banks and 1 = 16 KB banks.
REQ-012 The block SHALL have port rom_size, input, ADDR_W, ROM image size in bytes.
REQ-013 The block SHALL have port mem_addr, output, ADDR_W, the translated ROM address.
REQ-014 The block SHALL have port mem_unmaped, output, 1, asserted when the access lies outside the image.
REQ-015 The block SHALL have ports sram_sel, output, 1 (SRAM window active), sram_we, output, 1 (SRAM write strobe) and sram_addr, output, 13 (SRAM byte address).

Function
REQ-016 Each context SHALL hold four BANK_W-bit bank registers b0..b3.
REQ-017 A write commit SHALL occur only on the first cycle of cs & cpu_mreq & cpu_wr, using a registered previous value of that term; a held strobe SHALL yield exactly one commit.
REQ-018 In mode 0, a commit SHALL load din into: b0 for 6000-67FF, b1 for 6800-6FFF, b2 for 7000-77FF, b3 for 7800-7FFF.
REQ-019 In mode 0, mem_addr SHALL be {bank,cpu_addr[12:0]}, zero-extended to ADDR_W, where bank = b0 for 4000-5FFF, b1 for 6000-7FFF, b2 for 8000-9FFF and b3 for A000-BFFF.
REQ-020 In mode 1, a commit SHALL load b0 for 6000-67FF and b1 for 7000-77FF; writes to 6800-6FFF and 7800-7FFF SHALL be ignored.
REQ-021 In mode 1, mem_addr SHALL be {bank,cpu_addr[13:0]}, where bank = b0 for 4000-7FFF and b1 for 8000-BFFF.
REQ-022 Only din[BANK_W-1:0] SHALL be stored; if BANK_W > 8, the upper bits SHALL be zero-filled.
REQ-023 A written bank SHALL be visible on mem_addr in the cycle after the commit edge.
REQ-024 mem_addr SHALL be combinational from the bank registers and cpu_addr.
REQ-025 mem_unmaped SHALL equal cs & (mem_addr >= rom_size); when rom_size = 0, every cs access SHALL be unmapped.
REQ-026 Writes SHALL affect only the context selected by cart_num; a cart_num change mid-write SHALL direct the commit to the cart_num value sampled on the commit cycle.

Reset
REQ-027 reset_n low SHALL asynchronously clear all bank registers, all SRAM flags and the strobe history register.
REQ-028 While reset_n is low, outputs SHALL be mem_addr = {cpu_addr-derived offset with bank 0}, mem_unmaped per REQ-025, and sram_sel = sram_we = 0.
REQ-029 Reset asserted mid-write SHALL discard the write; after release, a still-held strobe SHALL NOT commit until it is deasserted and reasserted.

Configuration
REQ-030 With MAPPER_SRAM_EN defined, each bank shall have an SRAM flag set at commit from din[5] in mode 0 or din[4] in mode 1; a flagged bank in 8000-BFFF SHALL drive sram_sel=1, suppress mem_unmaped and set sram_addr=cpu_addr[12:0], and sram_we SHALL pulse for one cycle on the first cycle of a CPU write there.
REQ-031 With MAPPER_SRAM_EN defined, a flagged bank in 4000-7FFF SHALL be treated as ROM.
REQ-032 Without MAPPER_SRAM_EN, no SRAM flags SHALL exist, sram_sel, sram_we and sram_addr SHALL be tied to 0, and din[5]/din[4] SHALL be ordinary bank bits.

Structure
REQ-033 Window address constants, the mode enum (MODE_8K, MODE_16K) and the SRAM bit positions SHALL reside in the shared package mapper_pkg.
REQ-034 One sub-module, mapper_bank_regs, SHALL hold the per-context register file and the commit logic.

Verification
REQ-035 Scenario: mode 0, write 0x05 at 0x7000, read 0x8123 -> mem_addr = 0x00A123.
REQ-036 Scenario: mode 1, write 0x03 at 0x6000, read 0x4010 -> mem_addr = 0x00C010; write at 0x6800 -> no register changes.
REQ-037 Scenario: strobe held for 5 cycles with din changing each cycle -> only the first din is stored.
REQ-038 Scenario: cart_num=1, write 0x02 at 0x6000 -> context 0 b0 remains 0x00 and context 1 b0 = 0x02.
REQ-039 Scenario: rom_size = 0x8000, mode 0, b2 = 0x04, read 0x8000 -> mem_addr = 0x8000 and mem_unmaped = 1.
REQ-040 Scenario (MAPPER_SRAM_EN): mode 0, write 0x20 at 0x7000, write 3 cycles at 0x8010 -> sram_sel = 1, sram_addr = 0x0010, sram_we high for exactly 1 cycle.
